// File: rtl/loop_seq_pkg.sv
// Shared state codes and default loop constants for the fgIn/Fref start-up sequencer.
// The state codes are also decoded by the LED/test-point logic.
package loop_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAMP    = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   localparam int DEF_LOCK_CNT  = 8;
   localparam int DEF_LOSS_CNT  = 4;
   localparam int DEF_ACQ_TMO   = 255;
   localparam int DEF_RETRY_CNT = 16;

   // Counter width that can hold the terminal count (at least 1 bit).
   function automatic int cnt_w(input int tc);
      return (tc < 1) ? 1 : $clog2(tc + 1);
   endfunction

endpackage

// File: rtl/loop_seq_sat_cnt.sv
// Sample-qualified counter: synchronous clear, increment enable, saturation at all-ones.
// hit flags the increment that makes the count equal TC, so the caller can act on that edge.
module sat_cnt #(
   parameter int W  = 4,
   parameter int TC = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam logic [W-1:0] TC_V = W'(TC);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_inc;
   logic         sat;

   assign sat     = &cnt;
   assign cnt_inc = cnt + W'(1);
   assign hit     = inc && !sat && (cnt_inc == TC_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !sat)
         cnt <= cnt_inc;
   end

endmodule

// File: rtl/loop_seq.sv
// Start-up and lock sequencer: ramps the open-loop PWM centre point, enables compensation,
// qualifies lock from phase-detector samples and falls back to open-loop default on timeout.
module loop_seq
   import loop_seq_pkg::*;
#(
   parameter int WIDTH     = 17,
   parameter int WIDTH_ERR = 22,
   parameter int M_START   = 500,
   parameter int M_DEF     = 950,
   parameter int RAMP_STEP = 10,
   parameter int LOCK_TOL  = 64,
   parameter int LOCK_CNT  = DEF_LOCK_CNT,
   parameter int LOSS_CNT  = DEF_LOSS_CNT,
   parameter int ACQ_TMO   = DEF_ACQ_TMO,
   parameter int RETRY_CNT = DEF_RETRY_CNT
) (
   input  logic                        sys_clk,
   input  logic                        reset_n,
   input  logic                        run,
   input  logic                        sample,
   input  logic                        pd_error,
   input  logic signed [WIDTH_ERR-1:0] err,
   output logic                        comp_en,
   output logic                        pwm_en,
   output logic [WIDTH-1:0]            m0_out,
   output logic                        locked,
   output logic                        fault,
   output logic [2:0]                  state_out
);

   localparam logic [WIDTH:0]       STEP_X = (WIDTH+1)'(RAMP_STEP);
   localparam logic [WIDTH:0]       MDEF_X = (WIDTH+1)'(M_DEF);
   localparam logic [WIDTH_ERR-1:0] TOL_V  = WIDTH_ERR'(LOCK_TOL);

   state_t               state, nx;
   logic [WIDTH-1:0]     m0_nx;
   logic [WIDTH:0]       sum;
   logic [WIDTH_ERR-1:0] mag;
   logic                 good, xit;
   logic                 good_hit, bad_hit, acq_hit, retry_hit;

   // Most-negative error has no positive twin; saturate so it can never qualify.
   always_comb begin
      mag = err;
      if (err[WIDTH_ERR-1])
         mag = (err[WIDTH_ERR-2:0] == '0) ? '1 : -err;
   end

   assign good = !pd_error && (mag <= TOL_V);
   assign sum  = {1'b0, m0_out} + STEP_X;

   always_comb begin
      nx    = state;
      m0_nx = m0_out;
      if (!run) begin
         nx    = ST_IDLE;
         m0_nx = WIDTH'(M_START);
      end else begin
         case (state)
            ST_IDLE: nx = ST_RAMP;
            ST_RAMP:
               if (sample) begin
                  if (sum >= MDEF_X) begin
                     m0_nx = WIDTH'(M_DEF);
                     nx    = ST_ACQUIRE;
                  end else begin
                     m0_nx = sum[WIDTH-1:0];
                  end
               end
            ST_ACQUIRE: begin
               m0_nx = WIDTH'(M_DEF);
               if (good_hit)
                  nx = ST_LOCKED;
               else if (acq_hit)
                  nx = ST_FAULT;
            end
            ST_LOCKED: if (bad_hit)   nx = ST_ACQUIRE;
            ST_FAULT:  if (retry_hit) nx = ST_ACQUIRE;
            default: begin
               nx    = ST_IDLE;
               m0_nx = WIDTH'(M_START);
            end
         endcase
      end
   end

   assign xit = (nx != state);

   sat_cnt #(.W(cnt_w(LOCK_CNT)), .TC(LOCK_CNT)) u_good (
      .clk(sys_clk), .rst_n(reset_n),
      .clr(xit || (sample && !good)),
      .inc(sample && good && (state == ST_ACQUIRE)),
      .hit(good_hit)
   );

   sat_cnt #(.W(cnt_w(ACQ_TMO)), .TC(ACQ_TMO)) u_acq (
      .clk(sys_clk), .rst_n(reset_n),
      .clr(xit),
      .inc(sample && (state == ST_ACQUIRE)),
      .hit(acq_hit)
   );

   sat_cnt #(.W(cnt_w(LOSS_CNT)), .TC(LOSS_CNT)) u_bad (
      .clk(sys_clk), .rst_n(reset_n),
      .clr(xit || (sample && good)),
      .inc(sample && !good && (state == ST_LOCKED)),
      .hit(bad_hit)
   );

   sat_cnt #(.W(cnt_w(RETRY_CNT)), .TC(RETRY_CNT)) u_retry (
      .clk(sys_clk), .rst_n(reset_n),
      .clr(xit),
      .inc(sample && (state == ST_FAULT)),
      .hit(retry_hit)
   );

   // Outputs are registered from the next state so comp_en only moves at transitions.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         comp_en <= 1'b0;
         pwm_en  <= 1'b0;
         locked  <= 1'b0;
         fault   <= 1'b0;
         m0_out  <= WIDTH'(M_START);
      end else begin
         state   <= nx;
         comp_en <= (nx == ST_ACQUIRE) || (nx == ST_LOCKED);
         pwm_en  <= (nx != ST_IDLE);
         locked  <= (nx == ST_LOCKED);
         fault   <= (nx == ST_FAULT);
         m0_out  <= m0_nx;
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_loop_seq.sv
// Scoreboard bench for loop_seq: a sample-level reference model queues expected outputs,
// a monitor compares them after each clock edge.
module tb_loop_seq;

   typedef struct packed {
      logic [2:0]  st;
      logic [16:0] m0;
      logic        comp;
      logic        pwm;
      logic        lk;
      logic        flt;
   } obs_t;

   logic               sys_clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               run = 1'b0;
   logic               sample = 1'b0;
   logic               pd_error = 1'b0;
   logic signed [21:0] err = '0;
   logic               comp_en, pwm_en, locked, fault;
   logic [16:0]        m0_out;
   logic [2:0]         state_out;

   int n_tests = 0;
   int n_fail  = 0;
   obs_t exp_q[$];

   // Reference model state: 0 idle, 1 ramp, 2 acquire, 3 locked, 4 fault.
   int mst = 0, mm0 = 500, gcnt = 0, bcnt = 0, acnt = 0, rcnt = 0;

   loop_seq dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .run(run), .sample(sample),
      .pd_error(pd_error), .err(err), .comp_en(comp_en), .pwm_en(pwm_en),
      .m0_out(m0_out), .locked(locked), .fault(fault), .state_out(state_out)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: run did not finish, actual timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic bit is_good(input int e, input bit pde);
      longint a;
      a = (e < 0) ? -longint'(e) : longint'(e);
      return !pde && (a <= 64);
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.st   = 3'(mst);
      o.m0   = 17'(mm0);
      o.comp = (mst == 2) || (mst == 3);
      o.pwm  = (mst != 0);
      o.lk   = (mst == 3);
      o.flt  = (mst == 4);
      return o;
   endfunction

   task automatic go(input int s);
      mst = s; gcnt = 0; bcnt = 0; acnt = 0; rcnt = 0;
   endtask

   task automatic model_step(input bit r, input bit s, input int e, input bit pde);
      bit g;
      g = is_good(e, pde);
      if (!r) begin
         go(0); mm0 = 500;
      end else case (mst)
         0: go(1);
         1: if (s) begin
               mm0 = (mm0 + 10 > 950) ? 950 : mm0 + 10;
               if (mm0 == 950) go(2);
            end
         2: if (s) begin
               gcnt = g ? gcnt + 1 : 0;
               acnt++;
               if (gcnt == 8) go(3);
               else if (acnt == 255) go(4);
            end
         3: if (s) begin
               bcnt = g ? 0 : bcnt + 1;
               if (bcnt == 4) go(2);
            end
         default: if (s) begin
               rcnt++;
               if (rcnt == 16) go(2);
            end
      endcase
   endtask

   task automatic cyc(input bit r, input bit s, input int e, input bit pde);
      @(negedge sys_clk);
      run = r; sample = s; err = e[21:0]; pd_error = pde;
      model_step(r, s, e, pde);
      exp_q.push_back(model_obs());
   endtask

   task automatic smp(input int e, input bit pde);
      cyc(1'b1, 1'b1, e, pde);
      repeat ($urandom_range(0, 1)) cyc(1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic chk_reset(input string tag);
      obs_t a;
      a = {state_out, m0_out, comp_en, pwm_en, locked, fault};
      n_tests++;
      if (a != {3'd0, 17'd500, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL %s: actual st=%0d m0=%0d comp=%b pwm=%b lk=%b flt=%b, required st=0 m0=500 others 0",
                  tag, a.st, a.m0, a.comp, a.pwm, a.lk, a.flt);
      end
   endtask

   // Monitor: one expectation per clock edge, checked shortly after the edge.
   initial begin
      obs_t a, x;
      forever begin
         @(posedge sys_clk);
         #2;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            a = {state_out, m0_out, comp_en, pwm_en, locked, fault};
            n_tests++;
            if (a !== x) begin
               n_fail++;
               $display("FAIL out@%0t: actual st=%0d m0=%0d comp=%b pwm=%b lk=%b flt=%b, required st=%0d m0=%0d comp=%b pwm=%b lk=%b flt=%b",
                        $time, a.st, a.m0, a.comp, a.pwm, a.lk, a.flt,
                        x.st, x.m0, x.comp, x.pwm, x.lk, x.flt);
            end
         end
      end
   end

   initial begin
      #23;
      chk_reset("reset_state");
      @(negedge sys_clk);
      reset_n = 1'b1;

      // Ramp 500 -> 950 in 45 samples, then acquire and lock on small errors.
      cyc(1'b1, 1'b0, 0, 1'b0);
      repeat (45) smp(0, 1'b0);
      repeat (8) smp(10, 1'b0);
      // Loss qualification: interrupted run of bad samples, then four in a row.
      repeat (3) smp(0, 1'b1);
      smp(5, 1'b0);
      repeat (4) smp(0, 1'b1);
      // One out-of-tolerance sample restarts the good run.
      for (int i = 1; i <= 13; i++) smp((i == 5) ? 65 : 10, 1'b0);
      repeat (4) smp(-3, 1'b1);
      // Most-negative error never qualifies: timeout, fault dwell, re-acquire.
      repeat (255) smp(-(1 << 21), 1'b0);
      repeat (16) smp(-(1 << 21), 1'b0);
      smp(-64, 1'b0);
      smp(64, 1'b0);

      // Stop mid-ramp together with a sample.
      cyc(1'b0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0);
      repeat (20) smp(0, 1'b0);
      cyc(1'b0, 1'b1, 0, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         int e;
         e = (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4000)) - 2000
                                           : int'($urandom_range(0, 140)) - 70);
         cyc($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1, e,
             $urandom_range(0, 9) == 0);
      end

      // Reach LOCKED, then assert reset between edges.
      cyc(1'b0, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0);
      repeat (45) smp(0, 1'b0);
      repeat (8) smp(-20, 1'b0);
      cyc(1'b1, 1'b0, 0, 1'b0);
      @(posedge sys_clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk_reset("async_reset");
      run = 1'b0; sample = 1'b0;
      mst = 0; mm0 = 500; go(0);
      @(negedge sys_clk);
      reset_n = 1'b1;
      cyc(1'b1, 1'b0, 0, 1'b0);
      repeat (3) smp(0, 1'b0);
      repeat (3) @(posedge sys_clk);
      #3;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
